// File: rtl/vga_scan_timing.sv
// Purpose: 640x480 VGA raster timing generator with registered colour/sync output stage.
// Latency: one pix_en tick from (x,y) to the matching r/g/b/hs/vs; frame_start is a one-clk pulse.
// Backpressure: none; the raster free-runs, advancing only on clk edges where pix_en=1.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pix_en            : pixel tick enabling all raster state
//   x, y              : current horizontal/vertical count fed to the renderer
//   r_in/g_in/b_in    : renderer colour for the current (x,y)
//   r/g/b, hs, vs     : registered colour and active-low syncs toward the DAC
//   vblank            : y within vertical blanking (combinational)
//   frame_start       : one-clk pulse when the raster wraps to (0,0)
//   snap_in/snap_out  : debug state; latched at vblank entry when VGA_SNAPSHOT_EN
//                       is defined, otherwise passed straight through
module vga_scan_timing #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int SNAP_W = 224
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [10:0]       x,
  output logic [10:0]       y,
  input  logic [2:0]        r_in,
  input  logic [2:0]        g_in,
  input  logic [2:0]        b_in,
  output logic [2:0]        r,
  output logic [2:0]        g,
  output logic [2:0]        b,
  output logic              hs,
  output logic              vs,
  output logic              vblank,
  output logic              frame_start,
  input  logic [SNAP_W-1:0] snap_in,
  output logic [SNAP_W-1:0] snap_out
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);
  localparam logic [10:0] H_VIS_C    = 11'(H_VIS);
  localparam logic [10:0] V_VIS_C    = 11'(V_VIS);
  localparam logic [10:0] V_VIS_LAST = 11'(V_VIS - 1);
  localparam logic [10:0] HS_FIRST   = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_VIS + V_FP + V_SYNC - 1);

  logic [10:0] r_hc;
  logic [10:0] r_vc;
  logic [2:0]  r_r;
  logic [2:0]  r_g;
  logic [2:0]  r_b;
  logic        r_hs;
  logic        r_vs;
  logic        r_fs;

  logic w_h_last;
  logic w_v_last;
  logic w_visible;
  logic w_hs_act;
  logic w_vs_act;
  logic w_vblank_entry;

  always_comb begin
    w_h_last       = (r_hc == H_LAST);
    w_v_last       = (r_vc == V_LAST);
    w_visible      = (r_hc < H_VIS_C) && (r_vc < V_VIS_C);
    w_hs_act       = (r_hc >= HS_FIRST) && (r_hc <= HS_LAST);
    w_vs_act       = (r_vc >= VS_FIRST) && (r_vc <= VS_LAST);
    // Last pixel of the last visible line: the next tick enters vblank.
    w_vblank_entry = w_h_last && (r_vc == V_VIS_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc <= '0;
      r_vc <= '0;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_fs <= 1'b0;
    end else begin
      // Pulse is clk-wide regardless of pix_en rate.
      r_fs <= 1'b0;
      if (pix_en) begin
        if (w_h_last) begin
          r_hc <= '0;
          r_vc <= w_v_last ? 11'd0 : r_vc + 11'd1;
        end else begin
          r_hc <= r_hc + 11'd1;
        end
        // Colour and sync share this stage so they stay aligned.
        r_r  <= w_visible ? r_in : 3'd0;
        r_g  <= w_visible ? g_in : 3'd0;
        r_b  <= w_visible ? b_in : 3'd0;
        r_hs <= ~w_hs_act;
        r_vs <= ~w_vs_act;
        r_fs <= w_h_last && w_v_last;
      end
    end
  end

`ifdef VGA_SNAPSHOT_EN
  logic [SNAP_W-1:0] r_snap;

  // Latch once per frame at vblank entry so renderer values never tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
    end else if (pix_en && w_vblank_entry) begin
      r_snap <= snap_in;
    end
  end

  assign snap_out = r_snap;
`else
  logic w_unused_entry;
  assign w_unused_entry = w_vblank_entry;
  assign snap_out       = snap_in;
`endif

  assign x           = r_hc;
  assign y           = r_vc;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign vblank      = (r_vc >= V_VIS_C);
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Purpose: bench for vga_scan_timing: full-size and reduced-geometry instances against a tick-count model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: none; pix_en patterns are driven by the bench.
module tb_vga_scan_timing;

  localparam int SNAP_W = 224;
`ifdef VGA_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  // Instance 0: default 800x525 geometry. Instance 1: 32x19 so whole frames fit the run.
  int gHV[2] = '{640, 16};
  int gHF[2] = '{16, 4};
  int gHS[2] = '{96, 6};
  int gHB[2] = '{48, 6};
  int gVV[2] = '{480, 12};
  int gVF[2] = '{10, 2};
  int gVS[2] = '{2, 2};
  int gVB[2] = '{33, 3};

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  logic [2:0] r_in, g_in, b_in;
  logic [SNAP_W-1:0] snap_in;

  logic [10:0] d0_x, d0_y, d1_x, d1_y;
  logic [2:0]  d0_r, d0_g, d0_b, d1_r, d1_g, d1_b;
  logic        d0_hs, d0_vs, d0_vb, d0_fs, d1_hs, d1_vs, d1_vb, d1_fs;
  logic [SNAP_W-1:0] d0_snap, d1_snap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_scan_timing u_def (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(d0_x), .y(d0_y),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .r(d0_r), .g(d0_g), .b(d0_b),
    .hs(d0_hs), .vs(d0_vs), .vblank(d0_vb), .frame_start(d0_fs),
    .snap_in(snap_in), .snap_out(d0_snap)
  );

  vga_scan_timing #(
    .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SNAP_W(SNAP_W)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(d1_x), .y(d1_y),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .r(d1_r), .g(d1_g), .b(d1_b),
    .hs(d1_hs), .vs(d1_vs), .vblank(d1_vb), .frame_start(d1_fs),
    .snap_in(snap_in), .snap_out(d1_snap)
  );

  // Reference model: the raster position is just the number of pixel ticks since reset.
  longint      m_n[2];
  logic [2:0]  m_r[2], m_g[2], m_b[2];
  logic        m_hs[2], m_vs[2], m_fs[2];
  logic [SNAP_W-1:0] m_snap[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int ht, vt, px, py;
      ht = gHV[i] + gHF[i] + gHS[i] + gHB[i];
      vt = gVV[i] + gVF[i] + gVS[i] + gVB[i];
      if (rst) begin
        m_n[i] = 0; m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
        m_hs[i] = 1; m_vs[i] = 1; m_fs[i] = 0; m_snap[i] = '0;
      end else begin
        m_fs[i] = 0;
        if (pix_en) begin
          px = int'(m_n[i] % ht);
          py = int'((m_n[i] / ht) % vt);
          if (px < gHV[i] && py < gVV[i]) begin
            m_r[i] = r_in; m_g[i] = g_in; m_b[i] = b_in;
          end else begin
            m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
          end
          m_hs[i] = !(px >= gHV[i] + gHF[i] && px < gHV[i] + gHF[i] + gHS[i]);
          m_vs[i] = !(py >= gVV[i] + gVF[i] && py < gVV[i] + gVF[i] + gVS[i]);
          m_n[i]  = m_n[i] + 1;
          if (m_n[i] % (ht * vt) == 0) m_fs[i] = 1;
          if (m_n[i] % ht == 0 && (m_n[i] / ht) % vt == gVV[i]) m_snap[i] = snap_in;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [SNAP_W-1:0] act, input logic [SNAP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic [10:0] ax, input logic [10:0] ay,
                            input logic [2:0] ar, input logic [2:0] ag, input logic [2:0] ab,
                            input logic ahs, input logic avs, input logic avb, input logic afs,
                            input logic [SNAP_W-1:0] asnap);
    int ht, vt, ex, ey;
    ht = gHV[i] + gHF[i] + gHS[i] + gHB[i];
    vt = gVV[i] + gVF[i] + gVS[i] + gVB[i];
    ex = int'(m_n[i] % ht);
    ey = int'((m_n[i] / ht) % vt);
    chk($sformatf("i%0d_x", i), SNAP_W'(ax), SNAP_W'(ex));
    chk($sformatf("i%0d_y", i), SNAP_W'(ay), SNAP_W'(ey));
    chk($sformatf("i%0d_r", i), SNAP_W'(ar), SNAP_W'(m_r[i]));
    chk($sformatf("i%0d_g", i), SNAP_W'(ag), SNAP_W'(m_g[i]));
    chk($sformatf("i%0d_b", i), SNAP_W'(ab), SNAP_W'(m_b[i]));
    chk($sformatf("i%0d_hs", i), SNAP_W'(ahs), SNAP_W'(m_hs[i]));
    chk($sformatf("i%0d_vs", i), SNAP_W'(avs), SNAP_W'(m_vs[i]));
    chk($sformatf("i%0d_vblank", i), SNAP_W'(avb), SNAP_W'(ey >= gVV[i]));
    chk($sformatf("i%0d_fs", i), SNAP_W'(afs), SNAP_W'(m_fs[i]));
    chk($sformatf("i%0d_snap", i), asnap, SNAP_EN ? m_snap[i] : snap_in);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_inst(0, d0_x, d0_y, d0_r, d0_g, d0_b, d0_hs, d0_vs, d0_vb, d0_fs, d0_snap);
    check_inst(1, d1_x, d1_y, d1_r, d1_g, d1_b, d1_hs, d1_vs, d1_vb, d1_fs, d1_snap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    int          adv;
    logic [2:0]  rgb;
    logic [10:0] x, y;
    logic [2:0]  r;
    logic        hs, vs, vb;
  } vec_t;

  initial begin
    vec_t tbl[11];
    int   k, pulses, first, hi;

    // Line-timing walk on the full-size instance, each row relative to the previous.
    tbl[0]  = '{0,   3'd5, 11'd0,   11'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,   3'd5, 11'd1,   11'd0, 3'd5, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{639, 3'd3, 11'd640, 11'd0, 3'd3, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1,   3'd3, 11'd641, 11'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{15,  3'd7, 11'd656, 11'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1,   3'd7, 11'd657, 11'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{95,  3'd7, 11'd752, 11'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1,   3'd7, 11'd753, 11'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{46,  3'd7, 11'd799, 11'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1,   3'd7, 11'd0,   11'd1, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1,   3'd6, 11'd1,   11'd1, 3'd6, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; pix_en = 1'b0; r_in = 0; g_in = 0; b_in = 0; snap_in = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_fs", SNAP_W'(d0_fs), SNAP_W'(1'b0));
    chk("rst_snap", d1_snap, '0);

    pix_en = 1'b1;
    for (int t = 0; t < 11; t++) begin
      r_in = tbl[t].rgb; g_in = tbl[t].rgb; b_in = tbl[t].rgb;
      repeat (tbl[t].adv) step();
      chk($sformatf("tbl%0d_x", t),  SNAP_W'(d0_x),  SNAP_W'(tbl[t].x));
      chk($sformatf("tbl%0d_y", t),  SNAP_W'(d0_y),  SNAP_W'(tbl[t].y));
      chk($sformatf("tbl%0d_r", t),  SNAP_W'(d0_r),  SNAP_W'(tbl[t].r));
      chk($sformatf("tbl%0d_hs", t), SNAP_W'(d0_hs), SNAP_W'(tbl[t].hs));
      chk($sformatf("tbl%0d_vs", t), SNAP_W'(d0_vs), SNAP_W'(tbl[t].vs));
      chk($sformatf("tbl%0d_vb", t), SNAP_W'(d0_vb), SNAP_W'(tbl[t].vb));
    end

    // Reset mid-line at x=300: raster restarts at (0,0) with idle outputs and no pulse.
    k = 0;
    while (!(d0_x == 11'd300 && d0_y == 11'd1) && k < 2000) begin step(); k++; end
    chk("reach_x300", SNAP_W'(d0_x == 11'd300), SNAP_W'(1'b1));
    do_reset();
    chk("mid_rst_x", SNAP_W'(d0_x), '0);
    chk("mid_rst_y", SNAP_W'(d0_y), '0);
    chk("mid_rst_hs", SNAP_W'(d0_hs), SNAP_W'(1'b1));
    chk("mid_rst_vs", SNAP_W'(d0_vs), SNAP_W'(1'b1));
    chk("mid_rst_r", SNAP_W'(d0_r), '0);
    chk("mid_rst_fs", SNAP_W'(d0_fs | d1_fs), '0);

    // Continuous pix_en on the small raster: pulses at ticks 608 and 1216 only.
    pulses = 0; first = -1;
    for (int c = 1; c <= 1216; c++) begin
      r_in = 3'($urandom_range(0, 7)); g_in = 3'($urandom_range(0, 7)); b_in = 3'($urandom_range(0, 7));
      step();
      if (d1_fs) begin pulses++; if (first < 0) first = c; end
    end
    chk("cont_pulses", SNAP_W'(pulses), SNAP_W'(2));
    chk("cont_first", SNAP_W'(first), SNAP_W'(608));

    // 1-of-4 pix_en: a single frame wrap still gives exactly one high clk.
    do_reset();
    hi = 0;
    for (int c = 0; c < 2440; c++) begin
      pix_en = (c % 4 == 0);
      step();
      if (d1_fs) hi++;
    end
    chk("slow_fs_cycles", SNAP_W'(hi), SNAP_W'(1));
    chk("slow_x", SNAP_W'(d1_x), SNAP_W'(2));
    chk("slow_y", SNAP_W'(d1_y), SNAP_W'(0));

    // Snapshot: snap_in changes mid-frame; registered build only updates at vblank entry.
    pix_en = 1'b1; snap_in = '0;
    do_reset();
    k = 0;
    while (d1_y != 11'd5 && k < 1000) begin step(); k++; end
    chk("reach_y5", SNAP_W'(d1_y), SNAP_W'(5));
    snap_in = SNAP_W'(16'hABCD);
    step();
    chk("snap_mid", d1_snap, SNAP_EN ? '0 : SNAP_W'(16'hABCD));
    k = 0;
    while (!(d1_y == 11'd11 && d1_x == 11'd31) && k < 1000) begin step(); k++; end
    chk("snap_pre", d1_snap, SNAP_EN ? '0 : SNAP_W'(16'hABCD));
    step();
    chk("snap_y", SNAP_W'(d1_y), SNAP_W'(12));
    chk("snap_post", d1_snap, SNAP_W'(16'hABCD));

    // Randomised traffic with occasional resets, checked every cycle by the model.
    for (int c = 0; c < 6000; c++) begin
      pix_en = ($urandom_range(0, 1) == 1);
      rst    = ($urandom_range(0, 499) == 0);
      r_in = 3'($urandom_range(0, 7)); g_in = 3'($urandom_range(0, 7)); b_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0)
        snap_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
